// File: rtl/ddr_app_responder.sv
// ---------------------------------------------------------------------------
// ddr_app_responder
//   Simulation-grade stand-in for a MIG DDR3 user interface. Holds a
//   word-addressed memory, accepts app_* commands and app_wdf_* data with MIG
//   handshake semantics and returns read data in command order after a fixed
//   latency.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   stall_i                 back-pressure injection: forces both readies low
//   init_calib_complete_o   rises CALIB_CYCLES+1 clocks after reset release
//   app_en_i/app_cmd_i/app_addr_i/app_rdy_o      command channel
//   app_wdf_wren_i/app_wdf_data_i/app_wdf_mask_i/app_wdf_end_i/app_wdf_rdy_o
//                                                write-data channel
//   app_rd_data_o/app_rd_data_valid_o/app_rd_data_end_o   read return
//   cmd_err_o               sticky: illegal command or wdf_end low on a beat
// ---------------------------------------------------------------------------
module ddr_app_responder #(
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 512,
    parameter int MEM_AW       = 10,
    parameter int RD_LATENCY   = 8,
    parameter int FIFO_AW      = 4,
    parameter int CALIB_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    output logic                    init_calib_complete_o,
    input  logic                    app_en_i,
    input  logic [2:0]              app_cmd_i,
    input  logic [ADDR_WIDTH-1:0]   app_addr_i,
    output logic                    app_rdy_o,
    input  logic                    app_wdf_wren_i,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data_i,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask_i,
    input  logic                    app_wdf_end_i,
    output logic                    app_wdf_rdy_o,
    output logic [DATA_WIDTH-1:0]   app_rd_data_o,
    output logic                    app_rd_data_valid_o,
    output logic                    app_rd_data_end_o,
    output logic                    cmd_err_o
);

    localparam int MW    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CALIB_CYCLES + 1);
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    // ---------------- calibration ----------------
    logic [CW-1:0] cal_cnt;
    logic          calib;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cal_cnt <= '0;
            calib   <= 1'b0;
        end else if (!calib) begin
            if (cal_cnt == CW'(CALIB_CYCLES)) calib   <= 1'b1;
            else                              cal_cnt <= cal_cnt + CW'(1);
        end
    end

    // ---------------- FIFOs ----------------
    // Command entry: {is_read, beat index}. Write-data entry: {data, mask}.
    logic [MEM_AW:0]          cmd_mem [DEPTH];
    logic [DATA_WIDTH+MW-1:0] wdf_mem [DEPTH];
    logic [FIFO_AW:0]         cmd_wr, cmd_rd, wdf_wr, wdf_rd;
    logic                     cmd_full, cmd_empty, wdf_full, wdf_empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign cmd_empty = (cmd_wr == cmd_rd);
    assign wdf_empty = (wdf_wr == wdf_rd);
    assign cmd_full  = (cmd_wr[FIFO_AW] != cmd_rd[FIFO_AW]) &&
                       (cmd_wr[FIFO_AW-1:0] == cmd_rd[FIFO_AW-1:0]);
    assign wdf_full  = (wdf_wr[FIFO_AW] != wdf_rd[FIFO_AW]) &&
                       (wdf_wr[FIFO_AW-1:0] == wdf_rd[FIFO_AW-1:0]);

    assign app_rdy_o     = calib & ~stall_i & ~cmd_full;
    assign app_wdf_rdy_o = calib & ~stall_i & ~wdf_full;

    logic cmd_legal, cmd_acc, cmd_push, wdf_push;
    assign cmd_legal = (app_cmd_i == 3'b000) || (app_cmd_i == 3'b001);
    assign cmd_acc   = app_en_i & app_rdy_o;
    assign cmd_push  = cmd_acc & cmd_legal;
    assign wdf_push  = app_wdf_wren_i & app_wdf_rdy_o;

    // ---------------- execute stage ----------------
    logic [MEM_AW:0]          head;
    logic                     head_rd;
    logic [MEM_AW-1:0]        head_beat;
    logic [DATA_WIDTH+MW-1:0] wdf_head;
    logic [DATA_WIDTH-1:0]    wdf_data;
    logic [MW-1:0]            wdf_mask;
    logic                     exec_rd, exec_wr;

    assign head      = cmd_mem[cmd_rd[FIFO_AW-1:0]];
    assign head_rd   = head[MEM_AW];
    assign head_beat = head[MEM_AW-1:0];
    assign wdf_head  = wdf_mem[wdf_rd[FIFO_AW-1:0]];
    assign wdf_data  = wdf_head[DATA_WIDTH+MW-1:MW];
    assign wdf_mask  = wdf_head[MW-1:0];

    // A write at the head with no data yet blocks everything behind it, which
    // is what keeps later reads ordered after the write.
    assign exec_rd = ~cmd_empty &  head_rd;
    assign exec_wr = ~cmd_empty & ~head_rd & ~wdf_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_wr <= '0;
            cmd_rd <= '0;
            wdf_wr <= '0;
            wdf_rd <= '0;
        end else begin
            if (cmd_push)          cmd_wr <= cmd_wr + PTR_ONE;
            if (exec_rd | exec_wr) cmd_rd <= cmd_rd + PTR_ONE;
            if (wdf_push)          wdf_wr <= wdf_wr + PTR_ONE;
            if (exec_wr)           wdf_rd <= wdf_rd + PTR_ONE;
        end
    end

    // FIFO storage needs no reset: pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (cmd_push)
            cmd_mem[cmd_wr[FIFO_AW-1:0]] <= {app_cmd_i[0], app_addr_i[MEM_AW+2:3]};
        if (wdf_push)
            wdf_mem[wdf_wr[FIFO_AW-1:0]] <= {app_wdf_data_i, app_wdf_mask_i};
    end

    // ---------------- memory (survives reset) ----------------
    logic [DATA_WIDTH-1:0] mem [1 << MEM_AW];

    always_ff @(posedge clk_i) begin
        if (exec_wr) begin
            for (int b = 0; b < MW; b++)
                if (!wdf_mask[b]) mem[head_beat][b*8 +: 8] <= wdf_data[b*8 +: 8];
        end
    end

    // ---------------- read return pipeline ----------------
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [DATA_WIDTH-1:0] dat_pipe [RD_LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= exec_rd;
            dat_pipe[0] <= exec_rd ? mem[head_beat] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign app_rd_data_o       = dat_pipe[RD_LATENCY-1];
    assign app_rd_data_valid_o = vld_pipe[RD_LATENCY-1];
    assign app_rd_data_end_o   = vld_pipe[RD_LATENCY-1];

    // ---------------- sticky protocol error ----------------
    logic err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err <= 1'b0;
        else if ((cmd_acc & ~cmd_legal) | (wdf_push & ~app_wdf_end_i)) err <= 1'b1;
    end

    assign cmd_err_o             = err;
    assign init_calib_complete_o = calib;

    // Low byte-lane bits and aliased upper bits carry no information here.
    logic unused_addr;
    assign unused_addr = ^{app_addr_i[2:0], app_addr_i[ADDR_WIDTH-1:MEM_AW+3]};

endmodule

// File: tb/tb_ddr_app_responder.sv
module tb_ddr_app_responder;

    localparam int RD_LATENCY   = 8;
    localparam int CALIB_CYCLES = 64;
    localparam int QDEPTH       = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   cmd = 3'd0;
    logic [29:0]  addr = '0;
    logic         wren = 1'b0;
    logic [511:0] wdata = '0;
    logic [63:0]  wmask = '0;
    logic         wend = 1'b1;
    logic         calib_o, rdy_o, wdf_rdy_o, rd_valid_o, rd_end_o, err_o;
    logic [511:0] rd_data_o;

    ddr_app_responder dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .init_calib_complete_o(calib_o),
        .app_en_i(en), .app_cmd_i(cmd), .app_addr_i(addr), .app_rdy_o(rdy_o),
        .app_wdf_wren_i(wren), .app_wdf_data_i(wdata), .app_wdf_mask_i(wmask),
        .app_wdf_end_i(wend), .app_wdf_rdy_o(wdf_rdy_o),
        .app_rd_data_o(rd_data_o), .app_rd_data_valid_o(rd_valid_o),
        .app_rd_data_end_o(rd_end_o), .cmd_err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no DUT response, expected one within the cycle budget", nm);
    endtask

    // ---------------- behavioural model ----------------
    // Queues of accepted work; one queued op retires per clock, reads land in
    // a table keyed by the cycle their data must appear.
    typedef struct { bit rd; int beat; } cmd_t;
    typedef struct { logic [511:0] d; logic [63:0] m; } wd_t;

    cmd_t         cq[$];
    wd_t          wq[$];
    logic [511:0] mmem [0:1023];
    logic [511:0] exp_rd [int];
    int           cyc  = 0;
    int           mcnt = 0;
    bit           mcal = 1'b0;
    bit           merr = 1'b0;
    int           mwc  = 0;   // write commands accepted
    int           mwd  = 0;   // write beats accepted

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cq.delete(); wq.delete(); exp_rd.delete();
            mcnt = 0; mcal = 1'b0; merr = 1'b0;
        end else begin
            bit c_ok, d_ok;
            cyc++;
            c_ok = mcal && !stall && cq.size() < QDEPTH;
            d_ok = mcal && !stall && wq.size() < QDEPTH;
            if (cq.size() > 0) begin
                if (cq[0].rd) begin
                    exp_rd[cyc + RD_LATENCY - 1] = mmem[cq[0].beat];
                    void'(cq.pop_front());
                end else if (wq.size() > 0) begin
                    for (int b = 0; b < 64; b++)
                        if (!wq[0].m[b]) mmem[cq[0].beat][b*8 +: 8] = wq[0].d[b*8 +: 8];
                    void'(cq.pop_front());
                    void'(wq.pop_front());
                end
            end
            if (en && c_ok) begin
                if (cmd == 3'b000 || cmd == 3'b001) begin
                    cq.push_back('{rd: (cmd == 3'b001), beat: int'(addr[12:3])});
                    if (cmd == 3'b000) mwc++;
                end else merr = 1'b1;
            end
            if (wren && d_ok) begin
                wq.push_back('{d: wdata, m: wmask});
                mwd++;
                if (!wend) merr = 1'b1;
            end
            if (!mcal) begin
                if (mcnt == CALIB_CYCLES) mcal = 1'b1;
                else mcnt++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ev;
        ev = exp_rd.exists(cyc);
        chk1("calib",   calib_o,   mcal);
        chk1("app_rdy", rdy_o,     mcal && !stall && cq.size() < QDEPTH);
        chk1("wdf_rdy", wdf_rdy_o, mcal && !stall && wq.size() < QDEPTH);
        chk1("rd_valid", rd_valid_o, ev);
        chk1("rd_end",   rd_end_o,   ev);
        chk1("cmd_err",  err_o,      merr);
        if (ev) chkw("rd_data", rd_data_o, exp_rd[cyc]);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Random aliasing bits above the beat index and random byte-lane bits.
    function automatic logic [29:0] mk_addr(input int beat);
        logic [29:0] a;
        a = 30'($urandom);
        a[12:3] = beat[9:0];
        return a;
    endfunction

    task automatic issue_cmd(input logic [2:0] c, input logic [29:0] a, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        @(negedge clk); #1;
        en = 1'b1; cmd = c; addr = a;
        for (int i = 0; i < 300; i++) begin
            if (rdy_o) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) fail_to("cmd_handshake");
        else begin @(posedge clk); #1; acc = cyc; end
    endtask

    task automatic issue_data(input logic [511:0] d, input logic [63:0] m, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        @(negedge clk); #1;
        wren = 1'b1; wdata = d; wmask = m;
        for (int i = 0; i < 300; i++) begin
            if (wdf_rdy_o) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) fail_to("wdf_handshake");
        else begin @(posedge clk); #1; acc = cyc; end
    endtask

    task automatic idle();
        @(negedge clk); #1;
        en = 1'b0; wren = 1'b0;
    endtask

    task automatic write_beat(input logic [29:0] a, input logic [511:0] d, input logic [63:0] m);
        int t1, t2;
        fork
            issue_cmd(3'b000, a, t1);
            issue_data(d, m, t2);
        join
        idle();
    endtask

    task automatic wait_valid(output logic [511:0] d, output int vc);
        bit ok;
        ok = 1'b0;
        d = '0;
        vc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_valid_o) begin d = rd_data_o; vc = cyc; ok = 1'b1; break; end
        end
        if (!ok) fail_to("rd_valid_wait");
    endtask

    task automatic wait_calib();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (calib_o) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("calib_wait");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [511:0] d, exp_d;
        int t, vc, n, pend;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_calib_low", calib_o, 1'b0);
        chkw("rst_rd_data_zero", rd_data_o, '0);
        rst = 1'b0;
        chk1("rdy_before_calib", rdy_o, 1'b0);

        // Calibration must land on the 65th rising edge after release.
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); n++; #1;
            if (calib_o) break;
        end
        chki("calib_edge_count", n, 65);
        @(negedge clk);
        chk1("rdy_after_calib", rdy_o, 1'b1);

        // Fill the beats the rest of the run reads from.
        for (int b = 0; b < 32; b++) write_beat(mk_addr(b), rnd512(), 64'd0);

        // Full-beat write then read: valid 8 edges after the read's accept
        // edge, i.e. cycle T+9 counting the accept cycle as T.
        exp_d = {64{8'hA5}};
        write_beat(30'h40, exp_d, 64'd0);
        issue_cmd(3'b001, 30'h40, t);
        idle();
        wait_valid(d, vc);
        chki("rd_latency", vc - t, 8);
        chkw("rd_data_a5", d, exp_d);

        // Byte mask: only byte 0 takes the new value.
        write_beat(30'h80, {64{8'hFF}}, 64'd0);
        write_beat(30'h80, '0, 64'hFFFF_FFFF_FFFF_FFFE);
        issue_cmd(3'b001, 30'h80, t);
        idle();
        wait_valid(d, vc);
        exp_d = {{63{8'hFF}}, 8'h00};
        chkw("masked_write", d, exp_d);

        // Write command well ahead of its data, read right behind it.
        exp_d = {16{32'h1234_5678}};
        issue_cmd(3'b000, 30'hC0, t);
        issue_cmd(3'b001, 30'hC0, t);
        idle();
        repeat (2) @(negedge clk);
        issue_data(exp_d, 64'd0, t);
        idle();
        wait_valid(d, vc);
        chkw("raw_data", d, exp_d);
        chki("raw_valid_after_data", vc - t, 9);

        // 16 back-to-back reads must return on 16 consecutive cycles.
        n = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) issue_cmd(3'b001, mk_addr(i), t);
                idle();
            end
            begin
                wait_valid(d, vc);
                if (vc >= 0) begin
                    n = 1;
                    for (int i = 0; i < 15; i++) begin
                        @(negedge clk);
                        if (rd_valid_o) n++;
                    end
                end
            end
        join
        chki("burst_valid_run", n, 16);

        // Stall held for three cycles while a read is offered.
        @(negedge clk); #1;
        stall = 1'b1; en = 1'b1; cmd = 3'b001; addr = mk_addr(5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_rdy_low", rdy_o, 1'b0);
        end
        #1 stall = 1'b0;
        #1 chk1("stall_release_rdy", rdy_o, 1'b1);
        @(posedge clk); #1;
        idle();
        repeat (12) @(negedge clk);

        // Randomised traffic; write data may lead or lag its command.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk); #1;
            pend  = mwc - mwd;
            stall = ($urandom % 8 == 0);
            en    = ($urandom % 2 == 1);
            cmd   = (($urandom % 3 == 0) && pend < 4) ? 3'b000 : 3'b001;
            addr  = mk_addr(int'($urandom % 32));
            wren  = ($urandom % 2 == 1) && (pend > -2);
            wdata = rnd512();
            wmask = ($urandom % 4 == 0) ? {$urandom, $urandom} : 64'd0;
        end
        idle();
        stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mwc - mwd <= 0) break;
            issue_data(rnd512(), 64'd0, t);
        end
        idle();
        repeat (30) @(negedge clk);

        // Reset mid-stream with four reads in flight.
        for (int i = 0; i < 4; i++) issue_cmd(3'b001, mk_addr(i), t);
        idle();
        #3 rst = 1'b1;
        #1;
        chk1("rst_now_rdy",    rdy_o,      1'b0);
        chk1("rst_now_wdfrdy", wdf_rdy_o,  1'b0);
        chk1("rst_now_calib",  calib_o,    1'b0);
        chk1("rst_now_valid",  rd_valid_o, 1'b0);
        chk1("rst_now_end",    rd_end_o,   1'b0);
        chk1("rst_now_err",    err_o,      1'b0);
        chkw("rst_now_data",   rd_data_o,  '0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (rd_valid_o) n++;
        end
        chki("no_valid_after_rst", n, 0);
        chk1("calib_after_rst", calib_o, 1'b1);

        // Illegal command: accepted, sets the sticky error.
        issue_cmd(3'b010, 30'h0, t);
        idle();
        @(negedge clk);
        chk1("illegal_cmd_err", err_o, 1'b1);
        repeat (10) @(negedge clk);
        chk1("illegal_cmd_sticky", err_o, 1'b1);

        // Reset clears it; a beat with wdf_end low sets it again.
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        #1 chk1("err_cleared", err_o, 1'b0);
        wait_calib();
        wend = 1'b0;
        issue_data(rnd512(), 64'd0, t);
        idle();
        wend = 1'b1;
        @(negedge clk);
        chk1("wdf_end_err", err_o, 1'b1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_app_responder.md
Name: ddr_app_responder

Overview:
- Simulation-grade responder for the MIG-style DDR3 user interface (app_*/app_wdf_*/app_rd_data_*) driven by the fc_op DDR initiator.
- Holds a word-addressed memory, accepts read/write commands with MIG handshake semantics and returns read data in command order after a fixed latency.
- Replaces the MIG plus DDR model in fully-connected layer benches.
- Optional back-pressure injection exercises the initiator's app_rdy/app_wdf_rdy handling.

Parameters:
ADDR_WIDTH, 30, app_addr width
DATA_WIDTH, 512, data beat width; mask width is DATA_WIDTH/8
MEM_AW, 10, log2 of memory depth in beats
RD_LATENCY, 8, cycles from read execution to app_rd_data_valid_o (≥1)
FIFO_AW, 4, log2 depth of the command FIFO and of the write-data FIFO
CALIB_CYCLES, 64, cycles after reset release before init_calib_complete_o rises

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
stall_i  in  1  forces app_rdy_o and app_wdf_rdy_o low (back-pressure injection)
init_calib_complete_o  out  1  calibration done
app_en_i  in  1  command valid
app_cmd_i  in  3  3'b000 write, 3'b001 read
app_addr_i  in  ADDR_WIDTH  byte-lane address, 8 per beat
app_rdy_o  out  1  command accepted when app_en_i & app_rdy_o
app_wdf_wren_i  in  1  write data valid
app_wdf_data_i  in  DATA_WIDTH  write data
app_wdf_mask_i  in  DATA_WIDTH/8  byte mask, 1 = byte not written
app_wdf_end_i  in  1  last beat of burst; always 1 in this mode
app_wdf_rdy_o  out  1  write data accepted when app_wdf_wren_i & app_wdf_rdy_o
app_rd_data_o  out  DATA_WIDTH  read data
app_rd_data_valid_o  out  1  read data valid
app_rd_data_end_o  out  1  equals app_rd_data_valid_o (single-beat)
cmd_err_o  out  1  sticky: illegal cmd, or app_wdf_end_i low on an accepted beat

Behaviour:
- Reset (asynchronous, rst_i high):
  - All outputs go to 0; app_rd_data_o = 0.
  - Both FIFOs are flushed, the read pipeline is cleared and the calibration counter restarts.
  - Memory contents are not cleared.
  - Reset asserted mid-operation drops all in-flight reads and writes silently.
- Calibration:
  - The counter counts CALIB_CYCLES clocks after rst_i falls.
  - init_calib_complete_o rises on the following edge and stays 1 until the next reset.
  - Before calibration completes, app_rdy_o = app_wdf_rdy_o = 0.
- Ready signals (both are registered-free combinational of state):
  - app_rdy_o = calib & ~stall_i & cmd FIFO not full.
  - app_wdf_rdy_o = calib & ~stall_i & wdf FIFO not full.
- Command accept:
  - Push {cmd, addr} into the command FIFO.
  - Beat index = app_addr_i[MEM_AW+2:3]; upper address bits alias (wrap). Low 3 bits are ignored.
  - An illegal cmd is accepted, not queued, and sets cmd_err_o.
- Data accept: push {data, mask} into the wdf FIFO. Data may precede, coincide with, or follow its write command, with any skew.
- Execute stage, at most one command per cycle, strictly in FIFO order:
  - Head is a write and the wdf FIFO is non-empty: pop both. Each byte b with mask[b] = 0 is written; masked bytes keep their old value.
  - Head is a write and the wdf FIFO is empty: stall the execute stage. Later reads wait behind it, which guarantees read-after-write ordering.
  - Head is a read: pop it, read the memory (write-first ordering with any write executed in the same cycle is impossible, since there is one op per cycle), and inject into an RD_LATENCY-deep valid/data shift pipeline.
  - Throughput is 1 read beat per cycle sustained.
- Read latency:
  - Read accepted at cycle T with an empty FIFO: executes at T+1, app_rd_data_valid_o at T+1+RD_LATENCY.
  - No back-pressure on read data; the initiator must always accept it.
- Simultaneous push and pop on a full FIFO:
  - Ready is already low, so no push occurs.
  - Push and pop in the same cycle on a non-full FIFO both occur and the count is unchanged.
- stall_i only gates acceptance; queued work continues to execute and return.

Test Plan:
- Reset release, CALIB_CYCLES=64 -> init_calib_complete_o rises exactly 65 cycles after rst_i falls; app_rdy_o is 0 before that and 1 after.
- Write addr 0x40, data all 0xA5 bytes, mask 0, then read 0x40 at cycle T -> app_rd_data_valid_o and app_rd_data_end_o pulse at T+9 with data all 0xA5.
- Write all 0xFF to addr 0x80, then write 0x00 with mask = 64'hFFFF_FFFF_FFFF_FFFE, read back -> byte 0 = 0x00, bytes 1..63 = 0xFF.
- Write command issued 5 cycles before its data, followed immediately by a read to the same address -> the read returns the new data, and valid is delayed until after the write executes.
- 16 back-to-back reads with stall_i=0 -> 16 consecutive valid cycles in address order. Hold stall_i=1 for 3 cycles -> app_rdy_o is 0 for exactly those cycles and no command is lost.
- Queue 4 reads, assert rst_i mid-stream -> all outputs 0 immediately and no further valid after release. app_cmd_i=3'b010 -> cmd_err_o=1 until reset.
